// File: rtl/kcsj_1_pkg.sv
// kcsj_1_pkg: shared prices, coin values and FSM state type for the vending controller.
package kcsj_1_pkg;
    localparam logic [3:0] PRICE       = 4'd5;
    localparam logic [3:0] COIN1_VALUE = 4'd1;
    localparam logic [3:0] COIN2_VALUE = 4'd2;
    localparam logic [3:0] MAX_CREDIT  = 4'd15;
    typedef enum logic {IDLE, VEND} state_e;
endpackage

// File: rtl/kcsj_1_edge_det.sv
// kcsj_1_edge_det: rising-edge detector against the previous-cycle sample.
module kcsj_1_edge_det (
    input  logic clk,
    input  logic reset,
    input  logic d_i,
    output logic rise_o
);
    logic prev_q;
    always_ff @(posedge clk) begin
        if (reset) prev_q <= 1'b0;
        else       prev_q <= d_i;
    end
    assign rise_o = d_i & ~prev_q;
endmodule

// File: rtl/kcsj_1.sv
// kcsj_1: coin-operated vending controller with credit, change and dispense pulses.
module kcsj_1
    import kcsj_1_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic       coin_1,
    input  logic       coin_2,
    input  logic       buy_button,
    output logic [3:0] total_coins_display,
    output logic [3:0] change_display,
    output logic       drink_dispensed,
    output logic       change_dispensed
);
    state_e     state_q, state_d;
    logic [3:0] credit_q, credit_d, change_q, change_d;
    logic       drink_q, drink_d, chg_q, chg_d;
    logic       c1_e, c2_e, buy_e, sale, coin_ok;
    logic [4:0] sum;

    kcsj_1_edge_det u_c1  (.clk(clk), .reset(reset), .d_i(coin_1),     .rise_o(c1_e));
    kcsj_1_edge_det u_c2  (.clk(clk), .reset(reset), .d_i(coin_2),     .rise_o(c2_e));
    kcsj_1_edge_det u_buy (.clk(clk), .reset(reset), .d_i(buy_button), .rise_o(buy_e));

    // 5-bit sum so an overflowing coin is caught before it can wrap
    assign sum = {1'b0, credit_q} + {1'b0, c1_e ? COIN1_VALUE : 4'd0}
               + {1'b0, c2_e ? COIN2_VALUE : 4'd0};
    assign sale    = (state_q == IDLE) && buy_e && (credit_q >= PRICE);
    assign coin_ok = (state_q == IDLE) && !buy_e && (c1_e || c2_e) && (sum <= {1'b0, MAX_CREDIT});

    always_ff @(posedge clk) begin
        if (reset) state_q <= IDLE;
        else       state_q <= state_d;
    end

    always_comb begin
        state_d = (state_q == VEND) ? IDLE : sale ? VEND : IDLE;
    end

    always_comb begin
        credit_d = sale ? 4'd0 : coin_ok ? sum[3:0] : credit_q;
        change_d = sale ? credit_q - PRICE : change_q;
        drink_d  = sale;
        chg_d    = sale && (credit_q != PRICE);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            credit_q <= 4'd0;
            change_q <= 4'd0;
            drink_q  <= 1'b0;
            chg_q    <= 1'b0;
        end else begin
            credit_q <= credit_d;
            change_q <= change_d;
            drink_q  <= drink_d;
            chg_q    <= chg_d;
        end
    end

    assign total_coins_display = credit_q;
    assign change_display      = change_q;
    assign drink_dispensed     = drink_q;
    assign change_dispensed    = chg_q;
endmodule

// File: tb/tb_kcsj_1.sv
// tb_kcsj_1: scoreboard bench for kcsj_1 with directed scenarios and random traffic.
module tb_kcsj_1;
    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       coin_1 = 1'b0, coin_2 = 1'b0, buy_button = 1'b0;
    logic [3:0] total_coins_display, change_display;
    logic       drink_dispensed, change_dispensed;

    typedef struct {
        int credit;
        int change;
        bit drink;
        bit chg;
    } exp_t;

    exp_t q[$];
    int   checks = 0, failures = 0;
    int   m_credit = 0, m_change = 0;
    bit   m_vend = 0, m_drink = 0, m_chg = 0;
    bit   p1 = 0, p2 = 0, pb = 0;

    kcsj_1 dut (
        .clk(clk), .reset(reset), .coin_1(coin_1), .coin_2(coin_2), .buy_button(buy_button),
        .total_coins_display(total_coins_display), .change_display(change_display),
        .drink_dispensed(drink_dispensed), .change_dispensed(change_dispensed)
    );

    always #5 clk = ~clk;

    task automatic step(input bit r, input bit a, input bit b, input bit y);
        bit e1, e2, eb;
        int s;
        @(negedge clk);
        reset = r; coin_1 = a; coin_2 = b; buy_button = y;
        e1 = a && !p1; e2 = b && !p2; eb = y && !pb;
        if (r) begin
            m_credit = 0; m_change = 0; m_vend = 0; m_drink = 0; m_chg = 0;
            p1 = 0; p2 = 0; pb = 0;
        end else begin
            m_drink = 0; m_chg = 0;
            if (m_vend) m_vend = 0;
            else if (eb) begin
                if (m_credit >= 5) begin
                    m_change = m_credit - 5; m_credit = 0;
                    m_vend = 1; m_drink = 1; m_chg = (m_change != 0);
                end
            end else if (e1 || e2) begin
                s = m_credit + (e1 ? 1 : 0) + (e2 ? 2 : 0);
                if (s <= 15) m_credit = s;
            end
            p1 = a; p2 = b; pb = y;
        end
        q.push_back('{m_credit, m_change, m_drink, m_chg});
    endtask

    task automatic cmp(input string name, input int act, input int req);
        checks++;
        if (act != req) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, req, $time);
        end
    endtask

    always @(posedge clk) begin
        #1;
        if (q.size() > 0) begin
            exp_t e;
            e = q.pop_front();
            cmp("total", int'(total_coins_display), e.credit);
            cmp("change", int'(change_display), e.change);
            cmp("drink", int'(drink_dispensed), int'(e.drink));
            cmp("chg_pulse", int'(change_dispensed), int'(e.chg));
        end
    end

    initial begin
        step(1, 0, 0, 0); step(1, 0, 0, 0);
        repeat (3) begin step(0, 0, 1, 0); step(0, 0, 0, 0); end
        repeat (5) step(0, 0, 0, 1);
        step(0, 0, 0, 0); step(0, 0, 0, 0);
        repeat (5) begin step(0, 1, 0, 0); step(0, 0, 0, 0); end
        step(0, 0, 0, 1); step(0, 0, 0, 0); step(0, 0, 0, 0);
        repeat (2) begin step(0, 0, 1, 0); step(0, 0, 0, 0); end
        step(0, 0, 0, 1); step(0, 0, 0, 0);
        step(0, 1, 0, 0); step(0, 0, 0, 0);
        step(0, 0, 0, 1); step(0, 0, 0, 0); step(0, 0, 0, 0);
        repeat (8) begin step(0, 0, 1, 0); step(0, 0, 0, 0); end
        step(0, 1, 0, 0); step(0, 0, 0, 0);
        step(0, 0, 0, 1); step(0, 0, 0, 0); step(0, 0, 0, 0);
        step(0, 1, 1, 0); step(0, 0, 0, 0);
        step(0, 0, 1, 0); step(0, 0, 0, 0);
        step(0, 0, 1, 1); step(0, 0, 0, 0); step(0, 0, 0, 0);
        repeat (5) begin step(0, 1, 0, 0); step(0, 0, 0, 0); end
        step(0, 0, 0, 1);
        step(1, 0, 1, 0); step(1, 0, 1, 0);
        step(0, 0, 1, 0); step(0, 0, 1, 0); step(0, 0, 0, 0);
        repeat (3000) step($urandom_range(0, 149) == 0, $urandom_range(0, 2) == 0,
                           $urandom_range(0, 2) == 0, $urandom_range(0, 4) == 0);
        for (int i = 0; i < 10 && q.size() > 0; i++) @(posedge clk);
        #3;
        if (q.size() > 0) begin
            failures++;
            $display("FAIL drain: %0d entries left, expected 0", q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
